sipo_word_assembler: RTL and testbench

- Serial-in / parallel-out word assembler that sits directly upstream of the team's 4-bit clock-enabled data register.
- Accepts one qualified serial bit per cycle, aligns on a sync marker and packs WIDTH bits into a word.
- Presents the word on out_data with a one-cycle out_ce strobe that drives the register's load enable directly.
- Also reports framing errors and keeps a running word count.

---
 rtl/sipo_pkg.sv | 13 +
 rtl/sipo_word_assembler.sv | 95 +++++++++
 tb/tb_sipo_word_assembler.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in / parallel-out word assembler.
// Imported by the assembler and its environment.
package sipo_pkg;

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 4;
  localparam int FRAME_CNT_W   = 8;

endpackage : sipo_pkg

// File: rtl/sipo_word_assembler.sv
// Aligns a qualified serial bit stream on a sync marker and packs WIDTH bits
// into a word, strobing out_ce for the downstream register's load enable.
module sipo_word_assembler
  import sipo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_bit,
  input  logic                   in_sync,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_ce,
  output logic                   sync_err,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       shreg_q, shreg_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;
  logic                   out_ce_q, out_ce_d;
  logic                   sync_err_q, sync_err_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                 input logic            b);
    if (MSB_FIRST) return {cur[WIDTH-2:0], b};
    else           return {b, cur[WIDTH-1:1]};
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    out_data_d  = out_data_q;
    out_ce_d    = 1'b0;
    sync_err_d  = 1'b0;
    frame_cnt_d = frame_cnt_q;

    if (in_valid) begin
      if (in_sync) begin
        // A marker always restarts the word; it is only an error if bits were pending.
        sync_err_d = (state_q == SHIFT) && (cnt_q != '0);
        state_d    = SHIFT;
        cnt_d      = ONE;
        shreg_d    = shift_in('0, in_bit);
      end else if (state_q == SHIFT) begin
        shreg_d = shift_in(shreg_q, in_bit);
        if (cnt_q == LAST_IDX) begin
          out_data_d  = shreg_d;
          out_ce_d    = 1'b1;
          frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      cnt_q       <= '0;
      shreg_q     <= '0;
      out_data_q  <= '0;
      out_ce_q    <= 1'b0;
      sync_err_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      out_data_q  <= out_data_d;
      out_ce_q    <= out_ce_d;
      sync_err_q  <= sync_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ce    = out_ce_q;
  assign sync_err  = sync_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule : sipo_word_assembler

// File: tb/tb_sipo_word_assembler.sv
// Bench for sipo_word_assembler: an MSB-first and an LSB-first instance share
// one stimulus stream and are compared every cycle against a bit-list model.
module tb_sipo_word_assembler;
  import sipo_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst, in_valid, in_bit, in_sync;
  logic [W-1:0] data_m, data_l;
  logic ce_m, ce_l, err_m, err_l;
  logic [FRAME_CNT_W-1:0] cnt_m, cnt_l;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sipo_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_sync(in_sync),
    .out_data(data_m), .out_ce(ce_m), .sync_err(err_m), .frame_cnt(cnt_m));

  sipo_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_sync(in_sync),
    .out_data(data_l), .out_ce(ce_l), .sync_err(err_l), .frame_cnt(cnt_l));

  // Model: remember the accepted bits of the current word in arrival order and
  // build both word orderings by arithmetic once WIDTH bits are collected.
  bit              aligned = 1'b0;
  bit              bits_q[$];
  logic [W-1:0]    exp_data_m = '0, exp_data_l = '0;
  logic            exp_ce = 1'b0, exp_err = 1'b0;
  logic [7:0]      exp_cnt = '0;

  always @(posedge clk) begin
    exp_ce  = 1'b0;
    exp_err = 1'b0;
    if (rst) begin
      aligned = 1'b0;
      bits_q.delete();
      exp_data_m = '0;
      exp_data_l = '0;
      exp_cnt    = '0;
    end else if (in_valid) begin
      if (in_sync) begin
        if (aligned && bits_q.size() != 0) exp_err = 1'b1;
        bits_q.delete();
        bits_q.push_back(in_bit);
        aligned = 1'b1;
      end else if (aligned) begin
        bits_q.push_back(in_bit);
      end
      if (bits_q.size() == W) begin
        int vm, vl;
        vm = 0;
        vl = 0;
        for (int i = 0; i < W; i++) begin
          vm += int'(bits_q[i]) * (2 ** (W - 1 - i));
          vl += int'(bits_q[i]) * (2 ** i);
        end
        exp_data_m = W'(vm);
        exp_data_l = W'(vl);
        exp_ce     = 1'b1;
        exp_cnt    = exp_cnt + 8'd1;
        bits_q.delete();
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_data_msb", 32'(data_m), 32'(exp_data_m));
      check("cyc_data_lsb", 32'(data_l), 32'(exp_data_l));
      check("cyc_ce_msb",   32'(ce_m),   32'(exp_ce));
      check("cyc_ce_lsb",   32'(ce_l),   32'(exp_ce));
      check("cyc_err_msb",  32'(err_m),  32'(exp_err));
      check("cyc_err_lsb",  32'(err_l),  32'(exp_err));
      check("cyc_cnt_msb",  32'(cnt_m),  32'(exp_cnt));
      check("cyc_cnt_lsb",  32'(cnt_l),  32'(exp_cnt));
    end
  end

  // Drive one cycle's inputs, then land just after the sampling edge.
  task automatic step(input logic v, input logic b, input logic s, input logic r = 1'b0);
    rst      = r;
    in_valid = v;
    in_bit   = b;
    in_sync  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic [W-1:0] bits_msb, input logic first_sync);
    for (int i = W - 1; i >= 0; i--)
      step(1'b1, bits_msb[i], (i == W - 1) ? first_sync : 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_sync = 1'b0;

    // 1. Reset held two cycles with in_valid toggling.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk_en = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("rst_data", 32'(data_m), 32'h0);
    check("rst_ce",   32'(ce_m),   32'h0);
    check("rst_err",  32'(err_m),  32'h0);
    check("rst_cnt",  32'(cnt_m),  32'h0);

    // 2. Basic word then back-to-back word without sync.
    word(4'b1011, 1'b1);
    check("t2_data_msb",  32'(data_m),     32'hB);
    check("t2_data_lsb",  32'(data_l),     32'hD);
    check("t2_model_msb", 32'(exp_data_m), 32'hB);
    check("t2_ce",        32'(ce_m),       32'h1);
    check("t2_cnt",       32'(cnt_m),      32'h1);
    step(1'b1, 1'b0, 1'b0);
    check("t2_ce_drop",   32'(ce_m),       32'h0);
    check("t2_data_hold", 32'(data_m),     32'hB);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("t2b_data", 32'(data_m), 32'h7);
    check("t2b_ce",   32'(ce_m),   32'h1);
    check("t2b_cnt",  32'(cnt_m),  32'h2);

    // 3. HUNT ignores unsynced bits; gaps with garbage on in_sync/in_bit.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("t3_hunt_ce", 32'(ce_m), 32'h0);
    for (int i = 0; i < W; i++) begin
      step(1'b1, (i == W - 1), (i == 0));
      if (i != W - 1) repeat (3) step(1'b0, 1'b1, 1'b1);
    end
    check("t3_data", 32'(data_m), 32'h1);
    check("t3_ce",   32'(ce_m),   32'h1);
    check("t3_cnt",  32'(cnt_m),  32'h1);

    // 4. Mid-word sync discards the partial word.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("t4_err",       32'(err_m),   32'h1);
    check("t4_model_err", 32'(exp_err), 32'h1);
    check("t4_ce_none",   32'(ce_m),    32'h0);
    step(1'b1, 1'b1, 1'b0);
    check("t4_err_drop",  32'(err_m),   32'h0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("t4_data", 32'(data_m), 32'hC);
    check("t4_cnt",  32'(cnt_m),  32'h1);

    // 5. Reset mid-word, then a stray bit is ignored in HUNT.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("t5_ce",   32'(ce_m),   32'h0);
    check("t5_data", 32'(data_m), 32'h0);
    check("t5_cnt",  32'(cnt_m),  32'h0);
    word(4'b1001, 1'b1);
    check("t5_data_after", 32'(data_m), 32'h9);

    // 6. LSB-first ordering, then frame counter wrap.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    word(4'b1000, 1'b1);
    check("t6_data_lsb", 32'(data_l),     32'h1);
    check("t6_model_lsb", 32'(exp_data_l), 32'h1);
    check("t6_data_msb", 32'(data_m),     32'h8);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 1; n <= 256; n++) begin
      word(W'($urandom_range(0, 2 ** W - 1)), (n == 1));
      if (n == 255) check("t6_cnt_255", 32'(cnt_m), 32'd255);
    end
    check("t6_wrap_cnt", 32'(cnt_m), 32'h0);
    check("t6_wrap_ce",  32'(ce_m),  32'h1);
    step(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sipo_word_assembler
